// File: rtl/axil_cfg_master_if.sv
// AXI4-Lite bundle between the command-driven cfg master and a register-file slave.
interface axil_cfg_master_if #(
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned DATA_BITS = 64
);
    logic [ADDR_BITS-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_BITS-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: one cmd beat in, one AW+W/B or AR/R exchange, one rsp beat out.
// Keeps saturating counts of completed writes, reads and error responses.
module axil_cfg_master #(
    parameter int unsigned CNT_BITS       = 32,
    parameter int unsigned AXI_ADDR_BITS  = 64,
    parameter int unsigned AXIL_DATA_BITS = 64
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_wr,
    input  logic [AXI_ADDR_BITS-1:0]    cmd_addr,
    input  logic [AXIL_DATA_BITS-1:0]   cmd_data,
    input  logic [AXIL_DATA_BITS/8-1:0] cmd_strb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_wr,
    output logic [AXIL_DATA_BITS-1:0]   rsp_data,
    output logic [1:0]                  rsp_resp,
    axil_cfg_master_if.master           axi_ctrl,
    output logic [CNT_BITS-1:0]         cnt_wr,
    output logic [CNT_BITS-1:0]         cnt_rd,
    output logic [CNT_BITS-1:0]         cnt_err
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

    state_t                        state_q, state_d;
    logic                          cmd_ready_q, cmd_ready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_wr_q, rsp_wr_d;
    logic [AXIL_DATA_BITS-1:0]     rsp_data_q, rsp_data_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          arvalid_q, arvalid_d;
    logic                          bready_q, bready_d;
    logic                          rready_q, rready_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic [AXI_ADDR_BITS-1:0]      addr_q, addr_d;
    logic [AXIL_DATA_BITS-1:0]     data_q, data_d;
    logic [AXIL_DATA_BITS/8-1:0]   strb_q, strb_d;
    logic                          wr_q, wr_d;
    logic [CNT_BITS-1:0]           cnt_wr_q, cnt_wr_d;
    logic [CNT_BITS-1:0]           cnt_rd_q, cnt_rd_d;
    logic [CNT_BITS-1:0]           cnt_err_q, cnt_err_d;
    logic                          aw_hs, w_hs;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign aw_hs = awvalid_q && axi_ctrl.awready;
    assign w_hs  = wvalid_q && axi_ctrl.wready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        wr_d        = wr_q;
        cnt_wr_d    = cnt_wr_q;
        cnt_rd_d    = cnt_rd_q;
        cnt_err_d   = cnt_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    strb_d      = cmd_strb;
                    wr_d        = cmd_wr;
                    if (cmd_wr) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W complete independently; either may finish first or both together.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                if (axi_ctrl.bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = axi_ctrl.bresp;
                    rsp_data_d  = '0;
                    rsp_wr_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_A: begin
                if (arvalid_q && axi_ctrl.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (axi_ctrl.rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = axi_ctrl.rresp;
                    rsp_data_d  = axi_ctrl.rdata;
                    rsp_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Statistics move on the edge that enters RSP.
        if (state_q != RSP && state_d == RSP) begin
            if (wr_q) cnt_wr_d = sat_inc(cnt_wr_q);
            else      cnt_rd_d = sat_inc(cnt_rd_q);
            if (rsp_resp_d != 2'b00) cnt_err_d = sat_inc(cnt_err_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            wr_q        <= 1'b0;
            cnt_wr_q    <= '0;
            cnt_rd_q    <= '0;
            cnt_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            wr_q        <= wr_d;
            cnt_wr_q    <= cnt_wr_d;
            cnt_rd_q    <= cnt_rd_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign cnt_wr    = cnt_wr_q;
    assign cnt_rd    = cnt_rd_q;
    assign cnt_err   = cnt_err_q;

    assign axi_ctrl.awaddr  = addr_q;
    assign axi_ctrl.awprot  = 3'b000;
    assign axi_ctrl.awvalid = awvalid_q;
    assign axi_ctrl.wdata   = data_q;
    assign axi_ctrl.wstrb   = strb_q;
    assign axi_ctrl.wvalid  = wvalid_q;
    assign axi_ctrl.bready  = bready_q;
    assign axi_ctrl.araddr  = addr_q;
    assign axi_ctrl.arprot  = 3'b000;
    assign axi_ctrl.arvalid = arvalid_q;
    assign axi_ctrl.rready  = rready_q;
endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master against a small register-file slave with programmable ready delays.
module tb_axil_cfg_master;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_data;
    logic [DW/8-1:0] cmd_strb;
    logic            rsp_valid, rsp_ready, rsp_wr;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_resp;
    logic [CW-1:0]   cnt_wr, cnt_rd, cnt_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 aclk = ~aclk;

    axil_cfg_master_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) axi ();

    axil_cfg_master #(
        .CNT_BITS      (CW),
        .AXI_ADDR_BITS (AW),
        .AXIL_DATA_BITS(DW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_strb (cmd_strb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_wr   (rsp_wr),
        .rsp_data (rsp_data),
        .rsp_resp (rsp_resp),
        .axi_ctrl (axi.master),
        .cnt_wr   (cnt_wr),
        .cnt_rd   (cnt_rd),
        .cnt_err  (cnt_err)
    );

    // Slave model: awready/wready rise after aw_lat/w_lat cycles of pending valid.
    int unsigned     aw_lat, w_lat;
    int unsigned     aw_wait = 0, w_wait = 0;
    logic            got_aw = 1'b0, got_w = 1'b0;
    logic [AW-1:0]   aw_addr_l;
    logic [DW-1:0]   w_data_l;
    logic [DW/8-1:0] w_strb_l;
    logic [1:0]      force_bresp, force_rresp;
    logic [DW-1:0]   mem [0:7];
    int unsigned     cyc = 0, aw_beats = 0, w_beats = 0, rsp_beats = 0, w_only = 0;
    int unsigned     aw_cyc = 0, w_cyc = 0;
    logic            aw_hs, w_hs;
    logic [2:0]      wr_idx;

    assign axi.awready = (aw_wait >= aw_lat);
    assign axi.wready  = (w_wait >= w_lat);
    assign axi.arready = 1'b1;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign wr_idx = aw_hs ? axi.awaddr[5:3] : aw_addr_l[5:3];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] strb);
        logic [DW-1:0] r = old;
        for (int i = 0; i < DW/8; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (rsp_valid && rsp_ready) rsp_beats <= rsp_beats + 1;
        if (axi.wvalid && !axi.awvalid) w_only <= w_only + 1;
        if (!aresetn) begin
            aw_wait    <= 0;
            w_wait     <= 0;
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rresp  <= 2'b00;
            axi.rdata  <= '0;
        end else begin
            if (axi.awvalid && !axi.awready) aw_wait <= aw_wait + 1;
            if (axi.wvalid && !axi.wready) w_wait <= w_wait + 1;
            if (aw_hs) begin
                aw_wait   <= 0;
                got_aw    <= 1'b1;
                aw_addr_l <= axi.awaddr;
                aw_beats  <= aw_beats + 1;
                aw_cyc    <= cyc;
            end
            if (w_hs) begin
                w_wait   <= 0;
                got_w    <= 1'b1;
                w_data_l <= axi.wdata;
                w_strb_l <= axi.wstrb;
                w_beats  <= w_beats + 1;
                w_cyc    <= cyc;
            end
            if ((aw_hs || got_aw) && (w_hs || got_w) && !axi.bvalid) begin
                mem[wr_idx] <= merge(mem[wr_idx], w_hs ? axi.wdata : w_data_l,
                                     w_hs ? axi.wstrb : w_strb_l);
                axi.bvalid <= 1'b1;
                axi.bresp  <= force_bresp;
                got_aw     <= 1'b0;
                got_w      <= 1'b0;
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= mem[axi.araddr[5:3]];
                axi.rresp  <= force_rresp;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, input int unsigned hold,
                           output logic [DW-1:0] r_data, output logic [1:0] r_resp,
                           output logic r_wr);
        int unsigned n = 0;
        logic stable = 1'b1;
        @(negedge aclk);
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_strb  = strb;
        @(negedge aclk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge aclk); n++; end
        check("rsp_wait", rsp_valid, 1);
        r_data = rsp_data;
        r_resp = rsp_resp;
        r_wr   = rsp_wr;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge aclk);
            if (!rsp_valid || rsp_data !== r_data || rsp_resp !== r_resp || cmd_ready) stable = 1'b0;
        end
        if (hold > 0) check("rsp_hold_stable", stable, 1);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        logic          rw;
        int unsigned   awb, wb, wo, rb;

        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        rsp_ready = 1'b0; aw_lat = 0; w_lat = 0; force_bresp = 2'b00; force_rresp = 2'b00;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
        check("rst_readies", {axi.bready, axi.rready}, 0);
        check("rst_prot", {axi.awprot, axi.arprot}, 0);
        check("rst_counters", {cnt_wr, cnt_rd, cnt_err}, 0);
        check("rst_rsp_fields", {rsp_wr, rsp_resp, rsp_data}, 0);
        aresetn = 1'b1;

        // Basic write, slave ready immediately
        awb = aw_beats; wb = w_beats;
        run_cmd(1'b1, 64'h0, 64'hDEAD_BEEF, 8'hFF, 0, rd, rr, rw);
        check("wr0_rsp_wr", rw, 1);
        check("wr0_resp", rr, 0);
        check("wr0_data", rd, 0);
        check("wr0_cnt_wr", cnt_wr, 1);
        check("wr0_aw_beats", aw_beats - awb, 1);
        check("wr0_w_beats", w_beats - wb, 1);
        check("wr0_aw_w_same_cycle", w_cyc - aw_cyc, 0);

        // Write 0x42 to 0x8 then read it back
        run_cmd(1'b1, 64'h8, 64'h42, 8'hFF, 0, rd, rr, rw);
        check("wr8_cnt_wr", cnt_wr, 2);
        run_cmd(1'b0, 64'h8, 64'hFFFF_FFFF, 8'h00, 0, rd, rr, rw);
        check("rd8_data", rd, 64'h42);
        check("rd8_resp", rr, 0);
        check("rd8_rsp_wr", rw, 0);
        check("rd8_cnt_rd", cnt_rd, 1);

        // awready three cycles ahead of wready
        w_lat = 3;
        awb = aw_beats; wb = w_beats; wo = w_only; rb = rsp_beats;
        run_cmd(1'b1, 64'h10, 64'h1234, 8'hFF, 0, rd, rr, rw);
        check("split_aw_beats", aw_beats - awb, 1);
        check("split_w_beats", w_beats - wb, 1);
        check("split_w_after_aw", w_cyc - aw_cyc, 3);
        check("split_w_only_cycles", w_only - wo, 3);
        check("split_rsp_beats", rsp_beats - rb, 1);
        check("split_data", rd, 0);
        check("split_cnt_wr", cnt_wr, 3);
        w_lat = 0;

        // Partial strobe, write counter already at all-ones
        run_cmd(1'b1, 64'h10, 64'hAAAA_AAAA_5555_5555, 8'h0F, 0, rd, rr, rw);
        check("strb_cnt_wr_sat", cnt_wr, 3);
        run_cmd(1'b0, 64'h10, 64'h0, 8'h00, 0, rd, rr, rw);
        check("strb_rd_data", rd, 64'h0000_0000_5555_5555);
        check("strb_cnt_rd", cnt_rd, 2);

        // SLVERR read
        force_rresp = 2'b10;
        run_cmd(1'b0, 64'h8, 64'h0, 8'h00, 0, rd, rr, rw);
        check("err_resp", rr, 2'b10);
        check("err_data", rd, 64'h42);
        check("err_cnt_err", cnt_err, 1);
        check("err_cnt_rd", cnt_rd, 3);
        force_rresp = 2'b00;

        // rsp_ready held off for 10 cycles
        run_cmd(1'b0, 64'h8, 64'h0, 8'h00, 10, rd, rr, rw);
        check("hold_data", rd, 64'h42);
        check("hold_resp", rr, 0);
        check("hold_cnt_rd_sat", cnt_rd, 3);
        check("hold_cnt_err", cnt_err, 1);

        // Reset while AW is stalled
        aw_lat = 100;
        rb = rsp_beats;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 64'h18; cmd_data = 64'h77; cmd_strb = 8'hFF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("mid_awvalid_pre", axi.awvalid, 1);
        check("mid_awready_pre", axi.awready, 0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_valids_post", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_counters", {cnt_wr, cnt_rd, cnt_err}, 0);
        aresetn = 1'b1;
        aw_lat = 0;
        repeat (6) @(negedge aclk);
        check("mid_no_rsp_valid", rsp_valid, 0);
        check("mid_no_rsp_beat", rsp_beats - rb, 0);
        check("mid_idle_awvalid", axi.awvalid, 0);
        check("mid_idle_cmd_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
